multicycle_sequencer: RTL and testbench

- Parametrised successor to the multicycle CPU microcode controller.
- Drives the state register and counts retired instructions.
- Adds variable-latency memory handshakes in the fetch and memory states, instruction-register latching, a HLT state and illegal-opcode flagging.
- Sits between the datapath/memory interface and the combinational control-signal decoder, which consumes `state`.

---
 rtl/multicycle_sequencer_pkg.sv | 50 +++++
 rtl/multicycle_sequencer_inst_class_decode.sv | 56 +++++
 rtl/multicycle_sequencer.sv | 138 +++++++++++++
 tb/tb_multicycle_sequencer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_sequencer_pkg
// Description : State encodings, opcode/func constants and instruction classes
//               shared by the multicycle sequencer and the control decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package multicycle_sequencer_pkg;

    localparam logic [2:0] ST_RST  = 3'd0;
    localparam logic [2:0] ST_IF   = 3'd1;
    localparam logic [2:0] ST_ID   = 3'd2;
    localparam logic [2:0] ST_EX   = 3'd3;
    localparam logic [2:0] ST_MEM  = 3'd4;
    localparam logic [2:0] ST_WB   = 3'd5;
    localparam logic [2:0] ST_HALT = 3'd6;

    localparam logic [3:0] OP_BNE   = 4'd0;
    localparam logic [3:0] OP_BEQ   = 4'd1;
    localparam logic [3:0] OP_BGZ   = 4'd2;
    localparam logic [3:0] OP_BLZ   = 4'd3;
    localparam logic [3:0] OP_ADI   = 4'd4;
    localparam logic [3:0] OP_ORI   = 4'd5;
    localparam logic [3:0] OP_LHI   = 4'd6;
    localparam logic [3:0] OP_LWD   = 4'd7;
    localparam logic [3:0] OP_SWD   = 4'd8;
    localparam logic [3:0] OP_JMP   = 4'd9;
    localparam logic [3:0] OP_JAL   = 4'd10;
    localparam logic [3:0] OP_RTYPE = 4'd15;

    localparam logic [5:0] FUNC_JPR = 6'd25;
    localparam logic [5:0] FUNC_JRL = 6'd26;
    localparam logic [5:0] FUNC_WWD = 6'd28;
    localparam logic [5:0] FUNC_HLT = 6'd29;

    typedef enum logic [3:0] {
        CLS_RALU,
        CLS_WWD,
        CLS_JR,
        CLS_HLT,
        CLS_BR,
        CLS_IALU,
        CLS_LD,
        CLS_ST,
        CLS_J,
        CLS_ILL
    } inst_class_t;

endpackage
`default_nettype wire

// File: rtl/multicycle_sequencer_inst_class_decode.sv
`default_nettype none
// ============================================================================
// Module      : inst_class_decode
// Description : Combinational map from an instruction word to its class and
//               the state in which that class retires.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_class_decode
    import multicycle_sequencer_pkg::*;
#(
    parameter int WORD_SIZE = 16
) (
    input  logic [WORD_SIZE-1:0] i_ir,
    output inst_class_t          o_cls,
    output logic [2:0]           o_last_st
);

    logic [3:0] w_op;
    logic [5:0] w_func;

    assign w_op   = i_ir[WORD_SIZE-1 -: 4];
    assign w_func = i_ir[5:0];

    always_comb begin
        o_cls = CLS_ILL;
        if (w_op == OP_RTYPE) begin
            case (w_func)
                FUNC_JPR, FUNC_JRL: o_cls = CLS_JR;
                FUNC_WWD:           o_cls = CLS_WWD;
                FUNC_HLT:           o_cls = CLS_HLT;
                default:            o_cls = CLS_RALU;
            endcase
        end else begin
            case (w_op)
                OP_BNE, OP_BEQ, OP_BGZ, OP_BLZ: o_cls = CLS_BR;
                OP_ADI, OP_ORI, OP_LHI:         o_cls = CLS_IALU;
                OP_LWD:                         o_cls = CLS_LD;
                OP_SWD:                         o_cls = CLS_ST;
                OP_JMP, OP_JAL:                 o_cls = CLS_J;
                default:                        o_cls = CLS_ILL;
            endcase
        end
    end

    always_comb begin
        o_last_st = ST_ID;
        case (o_cls)
            CLS_RALU, CLS_IALU, CLS_LD: o_last_st = ST_WB;
            CLS_WWD, CLS_BR:            o_last_st = ST_EX;
            CLS_ST:                     o_last_st = ST_MEM;
            default:                    o_last_st = ST_ID;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_sequencer
// Description : Multicycle CPU state sequencer with memory handshakes, IR
//               latch, HALT state and retired-instruction counter.
//               Optional stall counter under MULTICYCLE_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_sequencer
    import multicycle_sequencer_pkg::*;
#(
    parameter int WORD_SIZE = 16,
    parameter int CNT_W     = 16,
    parameter int STATE_W   = 4
) (
    input  logic                 clk,
    input  logic                 Reset,
    input  logic [WORD_SIZE-1:0] instruction,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic [STATE_W-1:0]   state,
    output logic [WORD_SIZE-1:0] ir,
    output logic                 inst_done,
    output logic [CNT_W-1:0]     num_inst,
    output logic                 halted,
    output logic                 illegal_op
`ifdef MULTICYCLE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]     stall_cycles
`endif
);

    logic [STATE_W-1:0]   r_state;
    logic [STATE_W-1:0]   w_next_state;
    logic [WORD_SIZE-1:0] r_ir;
    logic [CNT_W-1:0]     r_num_inst;
    inst_class_t          w_cls;
    logic [2:0]           w_last_st;
    logic [2:0]           w_st;
    logic                 w_hi_clear;
    logic                 w_in_if, w_in_id, w_in_ex, w_in_mem, w_in_wb, w_in_halt;
    logic                 w_inst_done;

    inst_class_decode #(
        .WORD_SIZE (WORD_SIZE)
    ) u_decode (
        .i_ir      (r_ir),
        .o_cls     (w_cls),
        .o_last_st (w_last_st)
    );

    // Encodings only use the low three bits; any set upper bit is an unencoded state.
    generate
        if (STATE_W > 3) begin : g_state_hi
            assign w_hi_clear = ~|r_state[STATE_W-1:3];
        end else begin : g_state_narrow
            assign w_hi_clear = 1'b1;
        end
    endgenerate

    assign w_st      = r_state[2:0];
    assign w_in_if   = w_hi_clear && (w_st == ST_IF);
    assign w_in_id   = w_hi_clear && (w_st == ST_ID);
    assign w_in_ex   = w_hi_clear && (w_st == ST_EX);
    assign w_in_mem  = w_hi_clear && (w_st == ST_MEM);
    assign w_in_wb   = w_hi_clear && (w_st == ST_WB);
    assign w_in_halt = w_hi_clear && (w_st == ST_HALT);

    always_comb begin
        w_next_state = STATE_W'(ST_RST);
        if (w_hi_clear) begin
            case (w_st)
                ST_RST: w_next_state = STATE_W'(ST_IF);
                ST_IF:  w_next_state = mem_ready ? STATE_W'(ST_ID) : STATE_W'(ST_IF);
                ST_ID: begin
                    if (w_cls == CLS_HLT)        w_next_state = STATE_W'(ST_HALT);
                    else if (w_last_st == ST_ID) w_next_state = STATE_W'(ST_IF);
                    else                         w_next_state = STATE_W'(ST_EX);
                end
                ST_EX: begin
                    if (w_last_st == ST_EX)                       w_next_state = STATE_W'(ST_IF);
                    else if (w_cls == CLS_LD || w_cls == CLS_ST)  w_next_state = STATE_W'(ST_MEM);
                    else                                          w_next_state = STATE_W'(ST_WB);
                end
                ST_MEM: begin
                    if (!mem_ready)               w_next_state = STATE_W'(ST_MEM);
                    else if (w_last_st == ST_MEM) w_next_state = STATE_W'(ST_IF);
                    else                          w_next_state = STATE_W'(ST_WB);
                end
                ST_WB:   w_next_state = STATE_W'(ST_IF);
                ST_HALT: w_next_state = STATE_W'(ST_HALT);
                default: w_next_state = STATE_W'(ST_RST);
            endcase
        end
    end

    // HLT retires in ID because its last state is ID; HALT itself never retires.
    assign w_inst_done = (w_in_id  && (w_last_st == ST_ID))
                      || (w_in_ex  && (w_last_st == ST_EX))
                      || (w_in_mem && (w_last_st == ST_MEM) && mem_ready)
                      ||  w_in_wb;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_state    <= STATE_W'(ST_RST);
            r_ir       <= '0;
            r_num_inst <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_in_if && mem_ready) r_ir <= instruction;
            if (w_inst_done)          r_num_inst <= r_num_inst + CNT_W'(1);
        end
    end

`ifdef MULTICYCLE_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cycles;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_stall_cycles <= '0;
        end else if ((w_in_if || w_in_mem) && !mem_ready) begin
            r_stall_cycles <= r_stall_cycles + CNT_W'(1);
        end
    end

    assign stall_cycles = r_stall_cycles;
`endif

    assign state      = r_state;
    assign ir         = r_ir;
    assign num_inst   = r_num_inst;
    assign inst_done  = w_inst_done;
    assign mem_req    = w_in_if || w_in_mem;
    assign halted     = w_in_halt;
    assign illegal_op = w_in_id && (w_cls == CLS_ILL);

endmodule
`default_nettype wire

// File: tb/tb_multicycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_sequencer
// Description : Directed self-checking bench for multicycle_sequencer
//               (CNT_W=4 to reach counter wrap); stall counter checked when
//               MULTICYCLE_PERF_CNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_sequencer;
    import multicycle_sequencer_pkg::*;

    localparam int WS = 16;
    localparam int CW = 4;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          Reset;
    logic [WS-1:0] instruction;
    logic          mem_ready;
    logic          mem_req;
    logic [SW-1:0] state;
    logic [WS-1:0] ir;
    logic          inst_done;
    logic [CW-1:0] num_inst;
    logic          halted;
    logic          illegal_op;
`ifdef MULTICYCLE_PERF_CNT_EN
    logic [CW-1:0] stall_cycles;
`endif

    int checks    = 0;
    int failures  = 0;
    int exp_cnt   = 0;
    int exp_stall = 0;

    typedef struct packed {
        logic [15:0] instr;
        logic [3:0]  cnt;
    } sb_t;
    sb_t sb_q[$];

    always #5 clk = ~clk;

    multicycle_sequencer #(
        .WORD_SIZE (WS),
        .CNT_W     (CW),
        .STATE_W   (SW)
    ) dut (
        .clk          (clk),
        .Reset        (Reset),
        .instruction  (instruction),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .state        (state),
        .ir           (ir),
        .inst_done    (inst_done),
        .num_inst     (num_inst),
        .halted       (halted),
        .illegal_op   (illegal_op)
`ifdef MULTICYCLE_PERF_CNT_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_stall();
`ifdef MULTICYCLE_PERF_CNT_EN
        chk("stall_cycles", 32'(stall_cycles), 32'(exp_stall % 16));
`endif
    endtask

    // Runs one instruction starting at the first cycle of IF; trace holds the
    // zero-wait state sequence, 3 bits per cycle.
    task automatic run_inst(input logic [15:0] instr, input logic [17:0] trace,
                            input int len, input int ifw, input int memw);
        logic [2:0] st;
        int         waits;
        bit         fin;
        bit         ill;
        bit         seen;
        sb_t        e;
        ill     = (instr[15:12] >= 4'd11) && (instr[15:12] <= 4'd14);
        exp_cnt = (exp_cnt + 1) % 16;
        sb_q.push_back('{instr: instr, cnt: 4'(exp_cnt)});
        for (int i = 0; i < len; i++) begin
            st    = trace[i*3 +: 3];
            waits = (st == ST_IF) ? ifw : ((st == ST_MEM) ? memw : 0);
            for (int w = 0; w <= waits; w++) begin
                fin         = (w == waits);
                mem_ready   = fin;
                instruction = (st == ST_IF && fin) ? instr : (16'hA5A5 ^ 16'(w));
                #2;
                chk("state", 32'(state), 32'(st));
                chk("mem_req", 32'(mem_req), 32'(st == ST_IF || st == ST_MEM));
                chk("inst_done", 32'(inst_done), 32'((i == len - 1) && fin));
                chk("illegal_op", 32'(illegal_op), 32'(ill && st == ST_ID));
                chk("halted", 32'(halted), 32'(0));
                if (st != ST_IF) chk("ir", 32'(ir), 32'(instr));
                chk_stall();
                if (!fin) exp_stall++;
                seen = inst_done;
                @(posedge clk);
                #1;
                if (seen) begin
                    if (sb_q.size() == 0) begin
                        chk("sb_unexpected_retire", 32'(sb_q.size()), 32'(1));
                    end else begin
                        e = sb_q.pop_front();
                        chk("num_inst", 32'(num_inst), 32'(e.cnt));
                        chk("ir_retired", 32'(ir), 32'(e.instr));
                    end
                end
            end
        end
    endtask

    localparam logic [17:0] TR_RALU = {ST_WB, ST_EX, ST_ID, ST_IF};
    localparam logic [17:0] TR_LD   = {ST_WB, ST_MEM, ST_EX, ST_ID, ST_IF};
    localparam logic [17:0] TR_ST   = {ST_MEM, ST_EX, ST_ID, ST_IF};
    localparam logic [17:0] TR_EX   = {ST_EX, ST_ID, ST_IF};
    localparam logic [17:0] TR_ID   = {ST_ID, ST_IF};

    initial begin
        time t0;
        Reset       = 1'b1;
        mem_ready   = 1'b0;
        instruction = '0;
        #3;
        chk("rst_state_async", 32'(state), 32'(ST_RST));
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", 32'(state), 32'(ST_RST));
        chk("rst_ir", 32'(ir), 32'(0));
        chk("rst_num_inst", 32'(num_inst), 32'(0));
        chk("rst_inst_done", 32'(inst_done), 32'(0));
        chk("rst_illegal_op", 32'(illegal_op), 32'(0));
        chk("rst_halted", 32'(halted), 32'(0));
        chk("rst_mem_req", 32'(mem_req), 32'(0));
        chk_stall();
        Reset = 1'b0;
        #2;
        chk("rst_release_state", 32'(state), 32'(ST_RST));
        @(posedge clk);
        #1;

        // Zero-wait mix: ADD, LWD, SWD, BNE, JMP
        t0 = $time;
        run_inst(16'hF000, TR_RALU, 4, 0, 0);
        run_inst(16'h7123, TR_LD,   5, 0, 0);
        run_inst(16'h8123, TR_ST,   4, 0, 0);
        run_inst(16'h0123, TR_EX,   3, 0, 0);
        run_inst(16'h9042, TR_ID,   2, 0, 0);
        chk("mix_cycles", 32'(($time - t0) / 10), 32'(18));
        chk("mix_num_inst", 32'(num_inst), 32'(5));

        // Wait states: 3 in IF, 2 in MEM
        t0 = $time;
        run_inst(16'h7456, TR_LD, 5, 3, 2);
        chk("lwd_wait_cycles", 32'(($time - t0) / 10), 32'(10));

        run_inst(16'hF01C, TR_EX,   3, 1, 0);
        run_inst(16'hF019, TR_ID,   2, 0, 0);
        run_inst(16'h4A01, TR_RALU, 4, 0, 0);
        run_inst(16'hB000, TR_ID,   2, 0, 0);
        run_inst(16'hE0FF, TR_ID,   2, 2, 0);

        // Asynchronous reset in the EX cycle of an LWD
        chk("sb_drained", 32'(sb_q.size()), 32'(0));
        mem_ready   = 1'b1;
        instruction = 16'h7777;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("pre_abort_state", 32'(state), 32'(ST_EX));
        #3;
        Reset = 1'b1;
        #1;
        chk("abort_state", 32'(state), 32'(ST_RST));
        chk("abort_num_inst", 32'(num_inst), 32'(0));
        chk("abort_ir", 32'(ir), 32'(0));
        chk("abort_mem_req", 32'(mem_req), 32'(0));
        chk("abort_inst_done", 32'(inst_done), 32'(0));
        exp_cnt   = 0;
        exp_stall = 0;
        chk_stall();
        @(posedge clk);
        #1;
        Reset = 1'b0;
        #2;
        chk("abort_release_state", 32'(state), 32'(ST_RST));
        @(posedge clk);
        #1;

        // Counter wrap with 4-bit counter
        for (int k = 1; k <= 17; k++) begin
            run_inst(16'hA000 | 16'(k), TR_ID, 2, 0, 0);
            if (k == 15) chk("wrap_15", 32'(num_inst), 32'(15));
            if (k == 16) chk("wrap_16", 32'(num_inst), 32'(0));
        end
        chk("wrap_17", 32'(num_inst), 32'(1));

        // HLT: retire on entry, then absorbing
        run_inst(16'hF01D, TR_ID, 2, 1, 0);
        for (int k = 0; k < 20; k++) begin
            mem_ready   = 1'($urandom_range(0, 1));
            instruction = 16'($urandom);
            #2;
            chk("halt_state", 32'(state), 32'(ST_HALT));
            chk("halt_halted", 32'(halted), 32'(1));
            chk("halt_inst_done", 32'(inst_done), 32'(0));
            chk("halt_mem_req", 32'(mem_req), 32'(0));
            chk("halt_illegal_op", 32'(illegal_op), 32'(0));
            chk("halt_num_inst", 32'(num_inst), 32'(2));
            chk_stall();
            @(posedge clk);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
